// File: rtl/lfsr_tap_search_ctrl.sv
// LFSR tap-pattern search sequencer.
// Latches a seed/target pair on start, walks the tap index through the LUT
// address {idx, seed} one candidate per clock, and reports the lowest
// matching index, the full match mask and a found flag.
module lfsr_tap_search_ctrl #(
    parameter int NUM_TAPS   = 9,
    parameter int IDX_W      = 4,
    parameter int DATA_W     = 7,
    parameter int EARLY_EXIT = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [DATA_W-1:0]       seed,
    input  logic [DATA_W-1:0]       target,
    output logic [IDX_W+DATA_W-1:0] lut_addr,
    input  logic [DATA_W-1:0]       lut_data,
    output logic                    busy,
    output logic                    done,
    output logic                    found,
    output logic [IDX_W-1:0]        tap_idx,
    output logic [NUM_TAPS-1:0]     match_mask
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);

    state_t            state;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] seed_q;
    logic [DATA_W-1:0] target_q;
    logic              hit;
    logic              last;

    // LUT address comes straight from registers, so it is stable all cycle
    assign lut_addr = {idx_q, seed_q};

    // Candidate compare and end-of-search decision for the current index
    always_comb begin
        hit  = (lut_data == target_q);
        last = (hit && (EARLY_EXIT != 0)) || (idx_q == LAST_IDX);
    end

    // Search FSM with registered status and result outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx_q      <= '0;
            seed_q     <= '0;
            target_q   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            found      <= 1'b0;
            tap_idx    <= '0;
            match_mask <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        seed_q     <= seed;
                        target_q   <= target;
                        idx_q      <= '0;
                        match_mask <= '0;
                        found      <= 1'b0;
                        tap_idx    <= '0;
                        busy       <= 1'b1;
                        state      <= SEARCH;
                    end
                end
                SEARCH: begin
                    for (int i = 0; i < NUM_TAPS; i++) begin
                        if (hit && (idx_q == IDX_W'(i))) match_mask[i] <= 1'b1;
                    end
                    // first hit wins; a miss-only scan reports all-ones
                    if (hit && !found) begin
                        found   <= 1'b1;
                        tap_idx <= idx_q;
                    end else if (last && !found) begin
                        tap_idx <= '1;
                    end
                    if (last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    // start is deliberately ignored here: no queuing
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_tap_search_ctrl.sv
// Bench for lfsr_tap_search_ctrl: an early-exit and a full-scan instance share
// stimulus; expected results are queued at start and compared at done.
module tb_lfsr_tap_search_ctrl;

    localparam int NT = 9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  seed = '0;
    logic [6:0]  target = '0;

    logic [10:0] a1, a0;
    logic [6:0]  l1, l0;
    logic        b1, d1, f1, b0, d0, f0;
    logic [3:0]  t1, t0;
    logic [8:0]  m1, m0;

    logic [6:0]  core [0:2047];

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       found;
        logic [3:0] tap;
        logic [8:0] mask;
        int         lat;
    } exp_t;

    exp_t q1[$];
    exp_t q0[$];

    assign l1 = core[a1];
    assign l0 = core[a0];

    always #5 clk = ~clk;

    lfsr_tap_search_ctrl #(.NUM_TAPS(NT), .IDX_W(4), .DATA_W(7), .EARLY_EXIT(1)) dut_ee (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .target(target),
        .lut_addr(a1), .lut_data(l1), .busy(b1), .done(d1), .found(f1),
        .tap_idx(t1), .match_mask(m1));

    lfsr_tap_search_ctrl #(.NUM_TAPS(NT), .IDX_W(4), .DATA_W(7), .EARLY_EXIT(0)) dut_fs (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .target(target),
        .lut_addr(a0), .lut_data(l0), .busy(b0), .done(d0), .found(f0),
        .tap_idx(t0), .match_mask(m0));

    // Reference search over the LUT contents at start time
    function automatic exp_t model(input logic [6:0] s, input logic [6:0] t, input bit ee);
        exp_t e;
        logic [3:0] i4;
        bit stop;
        e.found = 1'b0; e.tap = 4'hF; e.mask = '0; e.lat = NT; stop = 1'b0;
        for (int i = 0; i < NT; i++) begin
            i4 = 4'(i);
            if (!stop && core[{i4, s}] == t) begin
                e.mask[i] = 1'b1;
                if (!e.found) begin
                    e.found = 1'b1;
                    e.tap = i4;
                    if (ee) begin
                        e.lat = i + 1;
                        stop = 1'b1;
                    end
                end
            end
        end
        return e;
    endfunction

    // Called at a negedge; returns at the negedge in the cycle after the accepting edge
    task automatic push_and_start(input logic [6:0] s, input logic [6:0] t);
        q1.push_back(model(s, t, 1'b1));
        q0.push_back(model(s, t, 1'b0));
        seed = s; target = t; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({b1, b0} !== 2'b11)
            $display("FAIL start_accept busy=%b%b required=11", b1, b0);
        if ({b1, b0} !== 2'b11) failures++;
    endtask

    // Follows both instances to done, checking the address walk and results
    task automatic wait_done(input logic [6:0] s, input int inject_at);
        exp_t e;
        bit seen1 = 1'b0, seen0 = 1'b0;
        int cnt = 0;
        while (!(seen1 && seen0) && cnt <= NT + 4) begin
            if (b1) begin
                checks++;
                if (a1 !== {4'(cnt), s}) begin
                    failures++;
                    $display("FAIL ee_addr cnt=%0d got=%h required=%h", cnt, a1, {4'(cnt), s});
                end
            end
            if (b0) begin
                checks++;
                if (a0 !== {4'(cnt), s}) begin
                    failures++;
                    $display("FAIL fs_addr cnt=%0d got=%h required=%h", cnt, a0, {4'(cnt), s});
                end
            end
            if (d1) begin
                checks++;
                if (seen1 || q1.size() == 0) begin
                    failures++;
                    $display("FAIL ee_extra_done cnt=%0d", cnt);
                end else begin
                    seen1 = 1'b1;
                    e = q1.pop_front();
                    if ({b1, f1, t1, m1} !== {1'b0, e.found, e.tap, e.mask} || cnt != e.lat) begin
                        failures++;
                        $display("FAIL ee_result got f=%b t=%h m=%h lat=%0d required f=%b t=%h m=%h lat=%0d",
                                 f1, t1, m1, cnt, e.found, e.tap, e.mask, e.lat);
                    end
                end
            end
            if (d0) begin
                checks++;
                if (seen0 || q0.size() == 0) begin
                    failures++;
                    $display("FAIL fs_extra_done cnt=%0d", cnt);
                end else begin
                    seen0 = 1'b1;
                    e = q0.pop_front();
                    if ({b0, f0, t0, m0} !== {1'b0, e.found, e.tap, e.mask} || cnt != e.lat) begin
                        failures++;
                        $display("FAIL fs_result got f=%b t=%h m=%h lat=%0d required f=%b t=%h m=%h lat=%0d",
                                 f0, t0, m0, cnt, e.found, e.tap, e.mask, e.lat);
                    end
                end
            end
            if (cnt == inject_at) begin
                start = 1'b1; seed = 7'h10;
            end else if (cnt == inject_at + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (!(seen1 && seen0)) begin
            failures++;
            $display("FAIL done_timeout ee=%b fs=%b required=11", seen1, seen0);
        end
        checks++;
        if ({d1, d0, b1, b0} !== 4'b0000) begin
            failures++;
            $display("FAIL done_pulse_width done=%b%b busy=%b%b required=0000", d1, d0, b1, b0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; seed = 7'h33; target = 7'h44;
        repeat (2) @(negedge clk);
        checks++;
        if ({b1, d1, f1, t1, m1, a1} !== 27'd0 || {b0, d0, f0, t0, m0, a0} !== 27'd0) begin
            failures++;
            $display("FAIL reset_state ee=%h fs=%h required=0",
                     {b1, d1, f1, t1, m1, a1}, {b0, d0, f0, t0, m0, a0});
        end
        start = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({b1, d1, b0, d0} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_idle busy/done=%b%b%b%b required=0000", b1, d1, b0, d0);
        end
    endtask

    task automatic test_early_hit();
        push_and_start(7'h01, 7'h55);
        wait_done(7'h01, -10);
    endtask

    task automatic test_full_scan();
        push_and_start(7'h22, 7'h2A);
        wait_done(7'h22, -10);
    endtask

    task automatic test_no_match();
        push_and_start(7'h01, 7'h7F);
        wait_done(7'h01, -10);
    endtask

    // Mid-search start is ignored, then an immediate follow-up start is taken
    task automatic test_back_to_back();
        push_and_start(7'h22, 7'h7F);
        wait_done(7'h22, 2);
        push_and_start(7'h01, 7'h55);
        wait_done(7'h01, -10);
    endtask

    task automatic test_reset_mid_search();
        push_and_start(7'h22, 7'h2A);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (a1 !== 11'h122) begin
            failures++;
            $display("FAIL midrst_addr got=%h required=122", a1);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({b1, d1, f1, t1, m1, a1} !== 27'd0 || {b0, d0, f0, t0, m0, a0} !== 27'd0) begin
            failures++;
            $display("FAIL midrst_state ee=%h fs=%h required=0",
                     {b1, d1, f1, t1, m1, a1}, {b0, d0, f0, t0, m0, a0});
        end
        q1.delete(); q0.delete();
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({d1, d0} !== 2'b00) begin
                failures++;
                $display("FAIL midrst_no_done done=%b%b required=00", d1, d0);
            end
        end
        push_and_start(7'h01, 7'h55);
        wait_done(7'h01, -10);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) core[i] = 7'h00;
        core[{4'd3, 7'h01}] = 7'h55;
        core[{4'd2, 7'h22}] = 7'h2A;
        core[{4'd7, 7'h22}] = 7'h2A;
        @(negedge clk);
        test_reset();
        test_early_hit();
        test_full_scan();
        test_no_match();
        test_back_to_back();
        test_reset_mid_search();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lfsr_tap_search_ctrl.md
Name: lfsr_tap_search_ctrl

Overview:
Sequencer for the program-2 LFSR tap-pattern lookup table. On a start request it latches a 7-bit seed word (data_mem[64] value) and a 7-bit target word (data_mem[73] value). It then steps a tap index 0..NUM_TAPS-1 through the LUT address, one candidate per clock, comparing the LUT output against the target. It reports the lowest matching tap index, the full match mask, and a found flag to the program-2 top level.

Parameters:
NUM_TAPS, 9, number of maximal-length tap patterns searched (indices 0..NUM_TAPS-1); legal 1..16
IDX_W, 4, tap index width; LUT address = {idx, seed}
DATA_W, 7, seed/target/LUT data width
EARLY_EXIT, 1, 1 = stop at first match; 0 = always scan all NUM_TAPS indices

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  search request, sampled only in IDLE
seed  input  DATA_W  LFSR start word, latched on accepted start
target  input  DATA_W  expected LUT output, latched on accepted start
lut_addr  output  IDX_W+DATA_W  LUT address = {idx_q, seed_q}, driven from registers
lut_data  input  DATA_W  LUT read data, combinational from lut_addr (same cycle)
busy  output  1  high while in SEARCH
done  output  1  one-cycle pulse when search completes
found  output  1  at least one index matched; valid from done, held until next accepted start
tap_idx  output  IDX_W  lowest matching index; all-ones if none; held like found
match_mask  output  NUM_TAPS  bit i set if index i matched (only scanned indices can be set)

Behaviour:
- One clock domain. Reset is synchronous and active-low; no asynchronous logic.
- Reset (rst_n=0 at an edge) forces: state=IDLE; idx_q=0; seed_q=0; target_q=0; busy=0; done=0; found=0; tap_idx=0; match_mask=0; lut_addr=0.
- Reset mid-SEARCH aborts the search with no done pulse. Reset dominates start.
- FSM states: IDLE, SEARCH, DONE.
- IDLE, start=1 at an edge: latch seed_q/target_q; idx_q=0; clear match_mask, found, tap_idx; go to SEARCH; busy=1.
- IDLE, start=0: hold state and all result outputs.
- SEARCH, each cycle: hit = (lut_data == target_q), exact DATA_W-bit compare. At the next edge:
  - If hit: set match_mask[idx_q].
  - If hit and found was 0: found=1, tap_idx=idx_q.
  - If (hit and EARLY_EXIT=1) or idx_q==NUM_TAPS-1: go to DONE with done=1, busy=0.
  - Otherwise: idx_q=idx_q+1.
  - idx_q never exceeds NUM_TAPS-1, so there is no wrap-around.
- Leaving SEARCH with found=0: tap_idx = all ones (4'hF).
- DONE: lasts exactly one cycle with done=1, then returns to IDLE. start is ignored in DONE and SEARCH (no queuing).
- Latency:
  - Start accepted at edge E0; index k is compared in the cycle after edge E(k).
  - EARLY_EXIT=1, first match at k: done high during the cycle after edge E(k+1).
  - No match, or EARLY_EXIT=0: done high after edge E(NUM_TAPS).
- Back-to-back: the earliest next start is accepted in the IDLE cycle after DONE (turnaround of 1 cycle).
- Changes to seed/target inputs during SEARCH have no effect; only latched values are used.
- lut_addr is valid at all times from registers; in IDLE/DONE it holds the last value.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with start=1 -> state IDLE; all outputs 0; lut_addr=11'h000; no done.
- Early hit: LUT model core[{4'd3,7'h01}]=7'h55, others 0; seed=7'h01, target=7'h55, EARLY_EXIT=1 -> lut_addr steps 11'h001, 081, 101, 181; done 4 cycles after start edge; found=1, tap_idx=3, match_mask=9'h008.
- Full scan, multiple hits (EARLY_EXIT=0): core[{2,seed}]=core[{7,seed}]=target=7'h2A -> done after 9 search cycles; tap_idx=2, match_mask=9'h084, found=1.
- No match: target=7'h7F, LUT never returns 7'h7F -> done 9 cycles after start; found=0, tap_idx=4'hF, match_mask=0.
- Start ignored while busy: pulse start with new seed 7'h10 mid-SEARCH -> lut_addr low bits stay at the original seed; exactly one done pulse; the next start one cycle after done is accepted.
- Reset mid-search at idx 2 -> no done, all outputs 0 next cycle; a fresh start then runs normally from idx 0.
